main_mem_resp: RTL and testbench

Main-memory responder: the memory-side end of the CPU data-memory interface driven by the memory-access stage (chip-select, write enable, byte address, write data, read data). It holds word storage with single-cycle writes and same-cycle combinational reads, so the memory-access stage can capture load data into its writeback register. After reset it runs a zero-fill sequencer and reports readiness. It keeps sticky error flags and saturating access counters for bench and debug visibility.

---
 rtl/main_mem_pkg.sv | 18 +
 rtl/main_mem_array.sv | 30 +++
 rtl/main_mem_resp.sv | 175 +++++++++++++++++
 tb/tb_main_mem_resp.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/main_mem_pkg.sv
// main_mem_pkg
// Shared types and constants for the main-memory responder.
//   mem_state_e       : sequencer state (CLEAR zero-fills, READY serves accesses)
//   MEM_AW_DEFAULT    : default word-index width (1024 words)
//   MEM_CNT_W_DEFAULT : default access-counter width
//   WORD_OFF_W        : byte-offset bits below the word index
package main_mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } mem_state_e;

    localparam int unsigned MEM_AW_DEFAULT    = 10;
    localparam int unsigned MEM_CNT_W_DEFAULT = 16;
    localparam int unsigned WORD_OFF_W        = 2;

endpackage

// File: rtl/main_mem_array.sv
// main_mem_array
// 2^AW x 32 word storage: one synchronous write port, one asynchronous read port.
//   clk   : write clock
//   we    : write enable
//   waddr : write word index
//   wdata : write data
//   raddr : read word index
//   rdata : read data, combinational from raddr and current contents
module main_mem_array #(
    parameter int unsigned AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] words [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            words[waddr] <= wdata;
        end
    end

    assign rdata = words[raddr];

endmodule

// File: rtl/main_mem_resp.sv
// main_mem_resp
// Memory-side responder for the CPU data-memory interface. Zero-fills the
// array after reset, then serves single-cycle writes and combinational reads.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   mem_cs        : chip-select; any cycle with mem_cs=1 is an access
//   mem_wen       : 1 = write, 0 = read
//   mem_addr      : byte address; word index is mem_addr[AW+1:2]
//   mem_dat_in    : write data
//   mem_dat_out   : read data of an accepted read, otherwise 0
//   mem_ready     : zero-fill finished, accesses are honoured
//   err_clr       : clears sticky error flags (wins over same-cycle setting)
//   err_oor       : sticky, access above the array range
//   err_misalign  : sticky, access with non-zero byte offset
//   err_busy      : sticky, access while not ready
//   rd_cnt/wr_cnt : accepted reads/writes, saturating
module main_mem_resp
    import main_mem_pkg::*;
#(
    parameter int unsigned AW    = MEM_AW_DEFAULT,
    parameter int unsigned CNT_W = MEM_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_cs,
    input  logic             mem_wen,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_dat_in,
    output logic [31:0]      mem_dat_out,
    output logic             mem_ready,
    input  logic             err_clr,
    output logic             err_oor,
    output logic             err_misalign,
    output logic             err_busy,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [CNT_W-1:0] wr_cnt
);

    localparam int unsigned HI_SHIFT = AW + WORD_OFF_W;

    mem_state_e       state_q, state_d;
    logic [AW-1:0]    clr_idx_q, clr_idx_d;
    logic             ready_q, ready_d;
    logic             err_oor_q, err_oor_d;
    logic             err_mis_q, err_mis_d;
    logic             err_busy_q, err_busy_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;

    logic [AW-1:0]    word_idx;
    logic             in_range;
    logic             aligned;
    logic             accept;
    logic             acc_wr;
    logic             acc_rd;

    logic             arr_we;
    logic [AW-1:0]    arr_waddr;
    logic [31:0]      arr_wdata;
    logic [31:0]      arr_rdata;

    // Access decode
    always_comb begin
        word_idx = mem_addr[AW+1:WORD_OFF_W];
        in_range = (mem_addr >> HI_SHIFT) == '0;
        aligned  = mem_addr[WORD_OFF_W-1:0] == '0;
        accept   = mem_cs && (state_q == READY) && in_range && aligned;
        acc_wr   = accept && mem_wen;
        acc_rd   = accept && !mem_wen;
    end

    // Write port: the fill sequencer owns the port during CLEAR, so a CPU
    // access in that state can never disturb the zero-fill.
    always_comb begin
        if (state_q == CLEAR) begin
            arr_we    = 1'b1;
            arr_waddr = clr_idx_q;
            arr_wdata = '0;
        end else begin
            arr_we    = acc_wr;
            arr_waddr = word_idx;
            arr_wdata = mem_dat_in;
        end
    end

    main_mem_array #(
        .AW(AW)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .raddr (word_idx),
        .rdata (arr_rdata)
    );

    assign mem_dat_out = acc_rd ? arr_rdata : '0;

    // Sequencer next state
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        ready_d   = ready_q;
        case (state_q)
            CLEAR: begin
                clr_idx_d = clr_idx_q + AW'(1);
                if (clr_idx_q == '1) begin
                    state_d = READY;
                    ready_d = 1'b1;
                end
            end
            READY: begin
                ready_d = 1'b1;
            end
            default: begin
                state_d = CLEAR;
                ready_d = 1'b0;
            end
        endcase
    end

    // Sticky errors; a clear request masks anything set in the same cycle
    always_comb begin
        err_oor_d  = err_oor_q;
        err_mis_d  = err_mis_q;
        err_busy_d = err_busy_q;
        if (err_clr) begin
            err_oor_d  = 1'b0;
            err_mis_d  = 1'b0;
            err_busy_d = 1'b0;
        end else if (mem_cs) begin
            if (!in_range)           err_oor_d  = 1'b1;
            if (!aligned)            err_mis_d  = 1'b1;
            if (state_q != READY)    err_busy_d = 1'b1;
        end
    end

    // Saturating access counters
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (acc_rd && (rd_cnt_q != '1)) rd_cnt_d = rd_cnt_q + CNT_W'(1);
        if (acc_wr && (wr_cnt_q != '1)) wr_cnt_d = wr_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLEAR;
            clr_idx_q  <= '0;
            ready_q    <= 1'b0;
            err_oor_q  <= 1'b0;
            err_mis_q  <= 1'b0;
            err_busy_q <= 1'b0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            clr_idx_q  <= clr_idx_d;
            ready_q    <= ready_d;
            err_oor_q  <= err_oor_d;
            err_mis_q  <= err_mis_d;
            err_busy_q <= err_busy_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end

    assign mem_ready    = ready_q;
    assign err_oor      = err_oor_q;
    assign err_misalign = err_mis_q;
    assign err_busy     = err_busy_q;
    assign rd_cnt       = rd_cnt_q;
    assign wr_cnt       = wr_cnt_q;

endmodule

// File: tb/tb_main_mem_resp.sv
// tb_main_mem_resp
// Self-checking bench for main_mem_resp with directed scenarios and a
// randomized access stream compared against a word-array reference model.
module tb_main_mem_resp;

    localparam int AW      = 10;
    localparam int CNT_W   = 6;
    localparam int DEPTH   = 1 << AW;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             mem_cs;
    logic             mem_wen;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_dat_in;
    logic [31:0]      mem_dat_out;
    logic             mem_ready;
    logic             err_clr;
    logic             err_oor;
    logic             err_misalign;
    logic             err_busy;
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] wr_cnt;

    int n_chk;
    int n_fail;

    main_mem_resp #(
        .AW    (AW),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_cs       (mem_cs),
        .mem_wen      (mem_wen),
        .mem_addr     (mem_addr),
        .mem_dat_in   (mem_dat_in),
        .mem_dat_out  (mem_dat_out),
        .mem_ready    (mem_ready),
        .err_clr      (err_clr),
        .err_oor      (err_oor),
        .err_misalign (err_misalign),
        .err_busy     (err_busy),
        .rd_cnt       (rd_cnt),
        .wr_cnt       (wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: word array, edges since reset, sticky flags, counts
    logic [31:0] m_mem [DEPTH];
    int          m_edges;
    bit          m_oor, m_mis, m_busy;
    int          m_rd, m_wr;

    function automatic bit m_ready();
        return m_edges >= DEPTH;
    endfunction

    function automatic bit m_accept();
        return mem_cs && m_ready() && (mem_addr[31:12] == 20'd0) && (mem_addr[1:0] == 2'd0);
    endfunction

    function automatic logic [31:0] m_read();
        if (m_accept() && !mem_wen) return m_mem[mem_addr[11:2]];
        return 32'd0;
    endfunction

    task automatic drive(input bit cs, input bit wen, input logic [31:0] addr,
                         input logic [31:0] dat, input bit clr);
        mem_cs     = cs;
        mem_wen    = wen;
        mem_addr   = addr;
        mem_dat_in = dat;
        err_clr    = clr;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    // Advance one rising edge and apply the same edge to the model
    task automatic step();
        bit acc;
        @(posedge clk);
        acc = m_accept();
        if (rst) begin
            m_edges = 0;
            m_oor = 0; m_mis = 0; m_busy = 0;
            m_rd = 0; m_wr = 0;
            // zero-fill always completes before anything can be accepted
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'd0;
        end else begin
            if (err_clr) begin
                m_oor = 0; m_mis = 0; m_busy = 0;
            end else if (mem_cs) begin
                if (mem_addr[31:12] != 20'd0) m_oor  = 1;
                if (mem_addr[1:0] != 2'd0)    m_mis  = 1;
                if (!m_ready())               m_busy = 1;
            end
            if (acc && mem_wen) begin
                m_mem[mem_addr[11:2]] = mem_dat_in;
                if (m_wr < CNT_MAX) m_wr++;
            end
            if (acc && !mem_wen && m_rd < CNT_MAX) m_rd++;
            m_edges++;
        end
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", mem_ready); end
        n_chk++;
        if ({err_oor, err_misalign, err_busy} !== 3'b000) begin
            n_fail++; $display("FAIL reset_errs got %b want 000", {err_oor, err_misalign, err_busy});
        end
        n_chk++;
        if (rd_cnt !== '0 || wr_cnt !== '0) begin
            n_fail++; $display("FAIL reset_cnts got rd=%0d wr=%0d want 0/0", rd_cnt, wr_cnt);
        end
        for (int k = 1; k <= DEPTH; k++) begin
            step();
            n_chk++;
            if (mem_ready !== (k == DEPTH)) begin
                n_fail++; $display("FAIL fill_ready cycle %0d got %b want %b", k, mem_ready, k == DEPTH);
            end
        end
        drive(1'b1, 1'b0, 32'h0000_0FFC, 32'd0, 1'b0);
        n_chk++;
        if (mem_dat_out !== 32'h0) begin n_fail++; $display("FAIL read_top_word got %h want 0", mem_dat_out); end
        step();
        idle();
    endtask

    task automatic test_write_read();
        drive(1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        step();
        drive(1'b1, 1'b0, 32'h0000_0010, 32'd0, 1'b0);
        n_chk++;
        if (mem_dat_out !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_rd_data got %h want deadbeef", mem_dat_out); end
        step();
        n_chk++;
        if (wr_cnt !== CNT_W'(m_wr) || rd_cnt !== CNT_W'(m_rd)) begin
            n_fail++; $display("FAIL wr_rd_cnts got rd=%0d wr=%0d want rd=%0d wr=%0d", rd_cnt, wr_cnt, m_rd, m_wr);
        end
        drive(1'b1, 1'b0, 32'h0000_0014, 32'd0, 1'b0);
        n_chk++;
        if (mem_dat_out !== 32'h0) begin n_fail++; $display("FAIL read_neighbour got %h want 0", mem_dat_out); end
        step();
        idle();
    endtask

    task automatic test_oor();
        logic [CNT_W-1:0] wr0;
        wr0 = wr_cnt;
        drive(1'b1, 1'b1, 32'h0000_1000, 32'h1234_5678, 1'b0);
        step();
        n_chk++;
        if (err_oor !== 1'b1) begin n_fail++; $display("FAIL oor_flag got %b want 1", err_oor); end
        n_chk++;
        if (wr_cnt !== wr0) begin n_fail++; $display("FAIL oor_wrcnt got %0d want %0d", wr_cnt, wr0); end
        drive(1'b1, 1'b0, 32'h0000_0000, 32'd0, 1'b0);
        n_chk++;
        if (mem_dat_out !== 32'h0) begin n_fail++; $display("FAIL oor_alias got %h want 0", mem_dat_out); end
        step();
        idle();
    endtask

    task automatic test_misalign();
        drive(1'b1, 1'b0, 32'h0000_0002, 32'd0, 1'b0);
        n_chk++;
        if (mem_dat_out !== 32'h0) begin n_fail++; $display("FAIL mis_data got %h want 0", mem_dat_out); end
        step();
        n_chk++;
        if (err_misalign !== 1'b1) begin n_fail++; $display("FAIL mis_flag got %b want 1", err_misalign); end
        drive(1'b1, 1'b0, 32'h0000_0002, 32'd0, 1'b1);
        step();
        n_chk++;
        if ({err_oor, err_misalign, err_busy} !== 3'b000) begin
            n_fail++; $display("FAIL clr_priority got %b want 000", {err_oor, err_misalign, err_busy});
        end
        idle();
    endtask

    task automatic test_busy();
        int guard;
        do_reset();
        for (int i = 0; i < 5; i++) step();
        drive(1'b1, 1'b1, 32'h0000_0004, 32'hAAAA_5555, 1'b0);
        step();
        idle();
        n_chk++;
        if (err_busy !== 1'b1) begin n_fail++; $display("FAIL busy_flag got %b want 1", err_busy); end
        n_chk++;
        if (wr_cnt !== '0) begin n_fail++; $display("FAIL busy_wrcnt got %0d want 0", wr_cnt); end
        guard = 0;
        while (!m_ready() && guard < 2 * DEPTH) begin step(); guard++; end
        n_chk++;
        if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL busy_ready got %b want 1", mem_ready); end
        drive(1'b1, 1'b0, 32'h0000_0004, 32'd0, 1'b0);
        n_chk++;
        if (mem_dat_out !== 32'h0) begin n_fail++; $display("FAIL busy_word1 got %h want 0", mem_dat_out); end
        step();
        idle();
    endtask

    task automatic test_reset_restart();
        int low;
        drive(1'b1, 1'b1, 32'h0000_0100, 32'hCAFE_F00D, 1'b0);
        step();
        drive(1'b1, 1'b0, 32'h0000_0100, 32'd0, 1'b0);
        n_chk++;
        if (mem_dat_out !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL w40_data got %h want cafef00d", mem_dat_out); end
        step();
        do_reset();
        for (int i = 0; i < 100; i++) step();
        do_reset();
        low = 0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (mem_ready === 1'b0) low++;
            step();
        end
        n_chk++;
        if (low !== DEPTH || mem_ready !== 1'b1) begin
            n_fail++; $display("FAIL restart_low got %0d low cycles ready=%b want %0d ready=1", low, mem_ready, DEPTH);
        end
        n_chk++;
        if (rd_cnt !== '0 || wr_cnt !== '0) begin
            n_fail++; $display("FAIL restart_cnts got rd=%0d wr=%0d want 0/0", rd_cnt, wr_cnt);
        end
        drive(1'b1, 1'b0, 32'h0000_0100, 32'd0, 1'b0);
        n_chk++;
        if (mem_dat_out !== 32'h0) begin n_fail++; $display("FAIL restart_w40 got %h want 0", mem_dat_out); end
        step();
        idle();
    endtask

    task automatic test_random();
        logic [31:0] addr;
        logic [31:0] exp_dat;
        int          sel;
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)       addr = {22'd0, 4'($urandom_range(0, 15)), 2'b00};
            else if (sel == 7) addr = {22'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
            else if (sel == 8) addr = 32'h0000_1000 << $urandom_range(0, 19);
            else               addr = $urandom;
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, addr, $urandom,
                  $urandom_range(0, 19) == 0);
            exp_dat = m_read();
            n_chk++;
            if (mem_dat_out !== exp_dat) begin
                n_fail++; $display("FAIL rnd_data[%0d] addr %h got %h want %h", n, addr, mem_dat_out, exp_dat);
            end
            step();
            n_chk++;
            if ({err_oor, err_misalign, err_busy} !== {m_oor, m_mis, m_busy}) begin
                n_fail++; $display("FAIL rnd_errs[%0d] got %b want %b", n, {err_oor, err_misalign, err_busy}, {m_oor, m_mis, m_busy});
            end
            n_chk++;
            if (rd_cnt !== CNT_W'(m_rd) || wr_cnt !== CNT_W'(m_wr)) begin
                n_fail++; $display("FAIL rnd_cnts[%0d] got rd=%0d wr=%0d want rd=%0d wr=%0d", n, rd_cnt, wr_cnt, m_rd, m_wr);
            end
        end
        idle();
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        m_edges = 0;
        rst     = 1'b0;
        idle();
        test_reset();
        test_write_read();
        test_oor();
        test_misalign();
        test_busy();
        test_reset_restart();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
